// File: rtl/isram_responder_pkg.sv
// Shared constants and FSM encoding for the instruction-memory responder.
package isram_responder_pkg;

    localparam int unsigned INSN_W = 32;
    localparam int unsigned ADDR_W = 64;

    // Also used as the IFU reset PC.
    localparam logic [ADDR_W-1:0] ISRAM_BASE_ADDR = 64'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } isram_state_t;

endpackage

// File: rtl/isram_array.sv
// DEPTH x 32 word store: synchronous write, combinational read, no reset.
module isram_array
    import isram_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 4096
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] widx,
    input  logic [INSN_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] ridx,
    output logic [INSN_W-1:0]        rdata
);

    logic [INSN_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/isram_responder.sv
// Instruction-fetch slave: one request at a time, fixed latency, range-checked
// 32-bit read from a preloadable word array.
module isram_responder
    import isram_responder_pkg::*;
#(
    parameter int unsigned       DEPTH     = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ISRAM_BASE_ADDR,
    parameter int unsigned       LATENCY   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [INSN_W-1:0]        resp_rdata,
    output logic                     resp_err,
    input  logic                     init_we,
    input  logic [$clog2(DEPTH)-1:0] init_idx,
    input  logic [INSN_W-1:0]        init_wdata
);

    localparam int unsigned IW       = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
    localparam logic [ADDR_W:0] LIMIT = {1'b0, BASE_ADDR} + (65'(DEPTH) << 2);

    isram_state_t      state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] cap_addr;
    logic              accept;
    logic              cap_en;
    logic              cap_err;
    logic [IW-1:0]     rd_idx;
    logic [INSN_W-1:0] rd_data;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic [INSN_W-1:0] rdata_q;
    logic              err_q;

    isram_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk  (clk),
        .we   (init_we),
        .widx (init_idx),
        .wdata(init_wdata),
        .ridx (rd_idx),
        .rdata(rd_data)
    );

    // With LATENCY==1 the capture happens on the accept edge, before addr_q is loaded.
    assign cap_addr = (state == IDLE) ? req_addr : addr_q;
    assign cap_err  = (cap_addr[1:0] != 2'b00) || (cap_addr < BASE_ADDR)
                   || ({1'b0, cap_addr} >= LIMIT);
    assign rd_idx   = IW'((cap_addr - BASE_ADDR) >> 2);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        cap_en  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    accept = 1'b1;
                    cnt_n  = CNT_INIT;
                    if (LATENCY == 1) begin
                        state_n = RESP;
                        cap_en  = 1'b1;
                    end else begin
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                // cnt holds the WAIT cycles still to run after this one
                if (cnt == 4'd0) begin
                    state_n = RESP;
                    cap_en  = 1'b1;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            addr_q       <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            req_ready_q  <= (state_n == IDLE);
            resp_valid_q <= (state_n == RESP);
            if (accept) begin
                addr_q <= req_addr;
            end
            if (cap_en) begin
                err_q   <= cap_err;
                rdata_q <= cap_err ? '0 : rd_data;
            end
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_isram_responder.sv
// Directed bench: LATENCY=2 instance for main/corner cases, LATENCY=1 instance
// for back-to-back fetch spacing.
module tb_isram_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        init_we;
    logic [11:0] init_idx;
    logic [31:0] init_wdata;

    logic        req_valid, req_ready, resp_valid, resp_ready, resp_err;
    logic [63:0] req_addr;
    logic [31:0] resp_rdata;

    logic        req_valid1, req_ready1, resp_valid1, resp_ready1, resp_err1;
    logic [63:0] req_addr1;
    logic [31:0] resp_rdata1;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    isram_responder #(
        .DEPTH(4096),
        .BASE_ADDR(64'h8000_0000),
        .LATENCY(2)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .init_we(init_we), .init_idx(init_idx), .init_wdata(init_wdata)
    );

    isram_responder #(
        .DEPTH(4096),
        .BASE_ADDR(64'h8000_0000),
        .LATENCY(1)
    ) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1),
        .resp_rdata(resp_rdata1), .resp_err(resp_err1),
        .init_we(init_we), .init_idx(init_idx), .init_wdata(init_wdata)
    );

    typedef struct {
        logic [63:0] addr;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic preload(input logic [11:0] idx, input logic [31:0] data);
        init_we    = 1'b1;
        init_idx   = idx;
        init_wdata = data;
        tick();
        init_we    = 1'b0;
    endtask

    task automatic wait_resp(input int max_cycles);
        int n = 0;
        while (!resp_valid && n < max_cycles) begin
            tick();
            n++;
        end
        check("resp_timeout", {63'd0, resp_valid}, 64'd1);
    endtask

    // Full LATENCY=2 transaction with timing checks; resp_ready is held high.
    task automatic do_read(input string nm, input logic [63:0] addr,
                           input logic [31:0] exp_data, input logic exp_err);
        check({nm, "_req_ready"}, {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        tick();
        req_valid = 1'b0;
        req_addr  = 64'h0;
        check({nm, "_rv_n0"}, {63'd0, resp_valid}, 64'd0);
        tick();
        check({nm, "_rv_n1"}, {63'd0, resp_valid}, 64'd0);
        tick();
        check({nm, "_rv_n2"}, {63'd0, resp_valid}, 64'd1);
        check({nm, "_rdata"}, {32'd0, resp_rdata}, {32'd0, exp_data});
        check({nm, "_err"}, {63'd0, resp_err}, {63'd0, exp_err});
        tick();
        check({nm, "_rv_done"}, {63'd0, resp_valid}, 64'd0);
        check({nm, "_ready_done"}, {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        reset       = 1'b0;
        init_we     = 1'b0;
        init_idx    = '0;
        init_wdata  = '0;
        req_valid   = 1'b0;
        req_addr    = '0;
        resp_ready  = 1'b1;
        req_valid1  = 1'b0;
        req_addr1   = '0;
        resp_ready1 = 1'b1;

        vecs[0] = '{64'h0000_0000_8000_0000, 32'h0000_0413, 1'b0};
        vecs[1] = '{64'h0000_0000_8000_0004, 32'h0010_0073, 1'b0};
        vecs[2] = '{64'h0000_0000_8000_0008, 32'h1234_5678, 1'b0};
        vecs[3] = '{64'h0000_0000_8000_0002, 32'h0000_0000, 1'b1};
        vecs[4] = '{64'h0000_0000_7FFF_FFFC, 32'h0000_0000, 1'b1};
        vecs[5] = '{64'h0000_0000_8000_4000, 32'h0000_0000, 1'b1};
        vecs[6] = '{64'h0000_0000_8000_3FFC, 32'hCAFE_F00D, 1'b0};
        vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0000, 1'b1};

        // Reset state
        #12;
        check("rst_req_ready", {63'd0, req_ready}, 64'd0);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_rdata", {32'd0, resp_rdata}, 64'd0);
        check("rst_err", {63'd0, resp_err}, 64'd0);
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_ready", {63'd0, req_ready}, 64'd1);
        check("post_rst_ready1", {63'd0, req_ready1}, 64'd1);

        preload(12'd0, 32'h0000_0413);
        preload(12'd1, 32'h0010_0073);
        preload(12'd2, 32'h1234_5678);
        preload(12'd3, 32'h1111_1111);
        preload(12'd4095, 32'hCAFE_F00D);

        for (int i = 0; i < 8; i++) begin
            do_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_data, vecs[i].exp_err);
        end

        // Backpressure, with a write to the held word partway through
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 64'h8000_0004;
        tick();
        req_valid  = 1'b0;
        wait_resp(10);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_rv", i), {63'd0, resp_valid}, 64'd1);
            check($sformatf("bp%0d_rdata", i), {32'd0, resp_rdata}, 64'h0010_0073);
            check($sformatf("bp%0d_err", i), {63'd0, resp_err}, 64'd0);
            check($sformatf("bp%0d_ready", i), {63'd0, req_ready}, 64'd0);
            if (i == 1) begin
                init_we    = 1'b1;
                init_idx   = 12'd1;
                init_wdata = 32'hFFFF_0000;
            end
            tick();
            init_we = 1'b0;
        end
        resp_ready = 1'b1;
        tick();
        check("bp_release_rv", {63'd0, resp_valid}, 64'd0);
        check("bp_release_ready", {63'd0, req_ready}, 64'd1);
        do_read("bp_newword", 64'h8000_0004, 32'hFFFF_0000, 1'b0);

        // Write to idx3 on the same edge the read of idx3 is captured
        req_valid = 1'b1;
        req_addr  = 64'h8000_000C;
        tick();
        req_valid = 1'b0;
        tick();
        init_we    = 1'b1;
        init_idx   = 12'd3;
        init_wdata = 32'hDEAD_BEEF;
        tick();
        init_we    = 1'b0;
        check("coll_rv", {63'd0, resp_valid}, 64'd1);
        check("coll_rdata", {32'd0, resp_rdata}, 64'h1111_1111);
        tick();
        do_read("coll_after", 64'h8000_000C, 32'hDEAD_BEEF, 1'b0);

        // Reset asserted while in WAIT
        req_valid = 1'b1;
        req_addr  = 64'h8000_0000;
        tick();
        req_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("midrst_rv", {63'd0, resp_valid}, 64'd0);
        check("midrst_ready", {63'd0, req_ready}, 64'd0);
        tick();
        reset = 1'b1;
        tick();
        check("midrst_rel_ready", {63'd0, req_ready}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("midrst_nostale%0d", i), {63'd0, resp_valid}, 64'd0);
            tick();
        end
        do_read("midrst_retained", 64'h8000_0008, 32'h1234_5678, 1'b0);

        // LATENCY=1: continuous requests, accepts every other cycle
        req_valid1 = 1'b1;
        req_addr1  = 64'h8000_0000;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("l1_%0d_ready", i), {63'd0, req_ready1}, 64'd1);
            check($sformatf("l1_%0d_rv_lo", i), {63'd0, resp_valid1}, 64'd0);
            tick();
            check($sformatf("l1_%0d_rv_hi", i), {63'd0, resp_valid1}, 64'd1);
            check($sformatf("l1_%0d_busy", i), {63'd0, req_ready1}, 64'd0);
            check($sformatf("l1_%0d_rdata", i), {32'd0, resp_rdata1}, 64'h0000_0413);
            check($sformatf("l1_%0d_err", i), {63'd0, resp_err1}, 64'd0);
            tick();
        end
        req_valid1 = 1'b0;
        req_addr1  = 64'h8000_0005;
        req_valid1 = 1'b1;
        tick();
        req_valid1 = 1'b0;
        check("l1_misalign_err", {63'd0, resp_err1}, 64'd1);
        check("l1_misalign_rdata", {32'd0, resp_rdata1}, 64'd0);
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
